axis_right_shift_divide: RTL and testbench
==========================================

// Module: axis_right_shift_divide
//
// PURPOSE
// Registered AXI4-Stream scaler: divides each signed sample by 2**SHIFT via
// arithmetic right shift, with optional round-half-up and saturation to
// OUT_WIDTH. It undoes the x16 front-end gain ahead of the output/DAC path,
// with a 2-entry skid buffer so throughput stays at one sample per clock under
// backpressure.
//
// PARAMETERS
// IN_WIDTH   32  signed input sample width
// OUT_WIDTH  32  signed output width; must be <= IN_WIDTH
// SHIFT      4   right-shift amount (divide by 2**SHIFT); 0..IN_WIDTH-1
// ROUND      1   1: add 2**(SHIFT-1) before shifting (round half toward +inf); 0: floor
//
// PORTS
// aclk           in   1          clock; all logic on rising edge
// aresetn        in   1          asynchronous, active-low reset
// s_axis_tvalid  in   1          input sample valid
// s_axis_tready  out  1          input ready, registered
// s_axis_tdata   in   IN_WIDTH   signed input sample
// m_axis_tvalid  out  1          output sample valid, registered
// m_axis_tready  in   1          downstream ready
// m_axis_tdata   out  OUT_WIDTH  signed scaled sample, registered
// sat_clr        in   1          synchronous clear for sat_sticky
// sat_sticky     out  1          set when any transferred sample was saturated
//
// BEHAVIOUR
// - Reset (aresetn low, async): m_axis_tvalid=0, m_axis_tdata=0, sat_sticky=0,
//   skid empty, s_axis_tready=0. s_axis_tready goes 1 on the first aclk edge
//   after release.
// - Arithmetic: extend x to IN_WIDTH+1 bits; r = x + (ROUND && SHIFT>0 ?
//   2**(SHIFT-1) : 0); q = r >>> SHIFT. If q > 2**(OUT_WIDTH-1)-1, output max
//   positive. If q < -2**(OUT_WIDTH-1), output min negative. Otherwise output
//   q[OUT_WIDTH-1:0]. SHIFT=0 is a registered pass-through with saturation only.
// - Input transfer: s_axis_tvalid & s_axis_tready. Output transfer:
//   m_axis_tvalid & m_axis_tready.
// - Latency: 1 clock from input transfer to m_axis_tvalid when the output is
//   empty or draining.
// - Output register (OR) plus skid register (SK). Each holds a result and its
//   sat bit.
//   EMPTY: OR and SK invalid. On input transfer, load OR -> ONE.
//   ONE: OR valid. Input + output transfer: OR takes the new result (stay ONE).
//     Output transfer only -> EMPTY. Input only with m_axis_tready=0: the new
//     result goes to SK and s_axis_tready drops next cycle -> FULL.
//   FULL: OR and SK valid, s_axis_tready=0. On output transfer, OR<=SK,
//     SK invalid, s_axis_tready=1 -> ONE.
// - s_axis_tready = !SK_valid (registered). No combinational path from
//   m_axis_tready to s_axis_tready.
// - Once m_axis_tvalid is 1, m_axis_tdata is held until the transfer (AXIS
//   stability rule).
// - sat_sticky is set on the output transfer of a saturated sample.
//   sat_clr clears it. If a clear and a saturated transfer land in the same
//   cycle, set wins.
// - Reset mid-stream: all buffered samples are discarded with no partial output.
//
// TESTING
// 1 SHIFT=4, ROUND=1, ready=1: in 16, 24, 8, 7, -8, -24 -> out 1, 2, 1, 0, 0, -1,
//   each 1 cycle after its input, back-to-back.
// 2 ROUND=0, same inputs -> 1, 1, 0, 0, -1, -2.
// 3 OUT_WIDTH=16: in 0x7FFFFFFF -> 0x7FFF with sat_sticky=1. In 0x80000000 -> 0x8000.
//   In 0x0007FFF0 -> 0x7FFF with no saturation. Then sat_clr -> sat_sticky=0.
// 4 Backpressure: stream 1..20 (x16) with random m_axis_tready (~50%) -> out 1..20
//   in order, no loss or duplication, tready never 0 for 2 consecutive cycles
//   while the output is draining, tdata stable while stalled.
// 5 Round trip: random 28-bit signed x, left-shift by 4, feed through this block
//   with ROUND=1 -> output equals x exactly.
// 6 Assert aresetn low while FULL -> tvalid=0 immediately (async). After release,
//   no stale sample appears and tready=1 after 1 edge.

Source files
------------

// File: rtl/axis_right_shift_divide_if.sv
// AXI4-Stream handshake/data bundle shared by the scaler input and output.
// Signals: tvalid (source->sink), tready (sink->source), tdata (source->sink).
// master modport drives tvalid/tdata; slave modport drives tready.
interface axis_right_shift_divide_if #(
  parameter int WIDTH = 32
) ();
  logic             tvalid;
  logic             tready;
  logic [WIDTH-1:0] tdata;

  modport master (output tvalid, output tdata, input tready);
  modport slave  (input tvalid, input tdata, output tready);
endinterface

// File: rtl/axis_right_shift_divide.sv
// Signed divide-by-2**SHIFT with optional round-half-up and saturation to OUT_WIDTH.
// Latency: 1 clock from input transfer to m_axis.tvalid when output is empty/draining.
// Backpressure: 2-entry (output + skid) buffer; s_axis.tready = !skid_valid, registered.
// Ports: aclk, aresetn (async active-low); s_axis (slave: tvalid/tready/tdata, IN_WIDTH);
//        m_axis (master: tvalid/tready/tdata, OUT_WIDTH); sat_clr (sync clear of
//        sat_sticky); sat_sticky (set when a saturated sample leaves on m_axis).
module axis_right_shift_divide #(
  parameter int IN_WIDTH  = 32,
  parameter int OUT_WIDTH = 32,
  parameter int SHIFT     = 4,
  parameter int ROUND     = 1
) (
  input  logic                            aclk,
  input  logic                            aresetn,
  axis_right_shift_divide_if.slave        s_axis,
  axis_right_shift_divide_if.master       m_axis,
  input  logic                            sat_clr,
  output logic                            sat_sticky
);

  // Rounding constant 2**(SHIFT-1); guarded so SHIFT=0 never forms a negative shift.
  localparam int RSH = (SHIFT > 0) ? SHIFT - 1 : 0;
  localparam logic signed [IN_WIDTH:0] RND =
    (ROUND != 0 && SHIFT > 0) ? ({{IN_WIDTH{1'b0}}, 1'b1} << RSH) : '0;

  logic signed [IN_WIDTH:0] x_ext;
  logic signed [IN_WIDTH:0] r_sum;
  logic signed [IN_WIDTH:0] q_shr;
  logic [OUT_WIDTH-1:0]     res_dat;
  logic                     res_sat;

  // One extra bit of headroom so adding the rounding constant can never wrap.
  always_comb begin
    x_ext = {s_axis.tdata[IN_WIDTH-1], s_axis.tdata};
    r_sum = x_ext + RND;
    q_shr = r_sum >>> SHIFT;
    // q fits in OUT_WIDTH iff every bit from the MSB down to bit OUT_WIDTH-1 agrees.
    res_sat = (q_shr[IN_WIDTH:OUT_WIDTH-1] != {(IN_WIDTH-OUT_WIDTH+2){q_shr[IN_WIDTH]}});
    if (!res_sat)
      res_dat = q_shr[OUT_WIDTH-1:0];
    else if (q_shr[IN_WIDTH])
      res_dat = {1'b1, {(OUT_WIDTH-1){1'b0}}};
    else
      res_dat = {1'b0, {(OUT_WIDTH-1){1'b1}}};
  end

  logic                 or_vld, or_sat;
  logic [OUT_WIDTH-1:0] or_dat;
  logic                 sk_vld, sk_sat;
  logic [OUT_WIDTH-1:0] sk_dat;
  logic                 s_rdy;
  logic                 in_xfer, out_xfer, sk_vld_nxt;

  assign in_xfer  = s_axis.tvalid & s_rdy;
  assign out_xfer = or_vld & m_axis.tready;

  // Skid fills only when OR is held and a new sample arrives; empties on any output transfer.
  assign sk_vld_nxt = sk_vld ? !out_xfer : (or_vld & !out_xfer & in_xfer);

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      or_vld     <= 1'b0;
      or_sat     <= 1'b0;
      or_dat     <= '0;
      sk_vld     <= 1'b0;
      sk_sat     <= 1'b0;
      sk_dat     <= '0;
      s_rdy      <= 1'b0;
      sat_sticky <= 1'b0;
    end else begin
      if (!or_vld) begin
        if (in_xfer) begin
          or_vld <= 1'b1;
          or_dat <= res_dat;
          or_sat <= res_sat;
        end
      end else if (!sk_vld) begin
        if (in_xfer && out_xfer) begin
          or_dat <= res_dat;
          or_sat <= res_sat;
        end else if (out_xfer) begin
          or_vld <= 1'b0;
        end else if (in_xfer) begin
          sk_dat <= res_dat;
          sk_sat <= res_sat;
        end
      end else if (out_xfer) begin
        or_dat <= sk_dat;
        or_sat <= sk_sat;
      end
      sk_vld <= sk_vld_nxt;
      s_rdy  <= !sk_vld_nxt;

      // A saturated sample leaving in the same cycle as a clear keeps the flag set.
      if (out_xfer && or_sat)
        sat_sticky <= 1'b1;
      else if (sat_clr)
        sat_sticky <= 1'b0;
    end
  end

  assign s_axis.tready = s_rdy;
  assign m_axis.tvalid = or_vld;
  assign m_axis.tdata  = or_dat;

endmodule

// File: tb/tb_axis_right_shift_divide.sv
// Directed bench for axis_right_shift_divide: rounding, floor, saturation,
// backpressure ordering/stability, round trip and async reset while full.
module tb_axis_right_shift_divide;

  logic aclk = 1'b0;
  logic aresetn = 1'b0;
  logic clr_r = 1'b0, clr_f = 1'b0, clr_s = 1'b0;
  logic stk_r, stk_f, stk_s;

  int checks = 0;
  int fails  = 0;

  always #5 aclk = ~aclk;

  axis_right_shift_divide_if #(.WIDTH(32)) s_r ();
  axis_right_shift_divide_if #(.WIDTH(32)) m_r ();
  axis_right_shift_divide_if #(.WIDTH(32)) s_f ();
  axis_right_shift_divide_if #(.WIDTH(32)) m_f ();
  axis_right_shift_divide_if #(.WIDTH(32)) s_s ();
  axis_right_shift_divide_if #(.WIDTH(16)) m_s ();

  // Floor-mode DUT mirrors the rounding DUT's stimulus.
  assign s_f.tvalid = s_r.tvalid;
  assign s_f.tdata  = s_r.tdata;
  assign m_f.tready = m_r.tready;

  axis_right_shift_divide #(.IN_WIDTH(32), .OUT_WIDTH(32), .SHIFT(4), .ROUND(1)) dut_r (
    .aclk(aclk), .aresetn(aresetn), .s_axis(s_r), .m_axis(m_r), .sat_clr(clr_r), .sat_sticky(stk_r));
  axis_right_shift_divide #(.IN_WIDTH(32), .OUT_WIDTH(32), .SHIFT(4), .ROUND(0)) dut_f (
    .aclk(aclk), .aresetn(aresetn), .s_axis(s_f), .m_axis(m_f), .sat_clr(clr_f), .sat_sticky(stk_f));
  axis_right_shift_divide #(.IN_WIDTH(32), .OUT_WIDTH(16), .SHIFT(4), .ROUND(1)) dut_s (
    .aclk(aclk), .aresetn(aresetn), .s_axis(s_s), .m_axis(m_s), .sat_clr(clr_s), .sat_sticky(stk_s));

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic test_reset();
    s_r.tvalid = 1'b0; s_r.tdata = '0; m_r.tready = 1'b1;
    s_s.tvalid = 1'b0; s_s.tdata = '0; m_s.tready = 1'b1;
    aresetn = 1'b0;
    step(); step();
    checks++;
    if (m_r.tvalid !== 1'b0 || m_r.tdata !== 32'h0 || s_r.tready !== 1'b0 || stk_r !== 1'b0) begin
      fails++;
      $display("FAIL reset_state: vld=%b dat=%h rdy=%b stk=%b required 0 0 0 0",
               m_r.tvalid, m_r.tdata, s_r.tready, stk_r);
    end
    aresetn = 1'b1;
    #1;
    checks++;
    if (s_r.tready !== 1'b0) begin
      fails++; $display("FAIL reset_rdy_before_edge: got %b required 0", s_r.tready);
    end
    step();
    checks++;
    if (s_r.tready !== 1'b1 || s_s.tready !== 1'b1) begin
      fails++; $display("FAIL reset_rdy_after_edge: got %b/%b required 1", s_r.tready, s_s.tready);
    end
  endtask

  task automatic test_round_floor();
    logic [31:0] din [6];
    logic [31:0] exp_r [6];
    logic [31:0] exp_f [6];
    din   = '{32'd16, 32'd24, 32'd8, 32'd7, -32'sd8, -32'sd24};
    exp_r = '{32'd1, 32'd2, 32'd1, 32'd0, 32'd0, -32'sd1};
    exp_f = '{32'd1, 32'd1, 32'd0, 32'd0, -32'sd1, -32'sd2};
    m_r.tready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      s_r.tdata = din[i]; s_r.tvalid = 1'b1;
      if (i == 0) begin
        checks++;
        if (m_r.tvalid !== 1'b0) begin
          fails++; $display("FAIL latency_pre: vld=%b required 0", m_r.tvalid);
        end
      end
      step();
      checks++;
      if (m_r.tvalid !== 1'b1 || m_r.tdata !== exp_r[i]) begin
        fails++; $display("FAIL round[%0d]: vld=%b dat=%h required 1 %h", i, m_r.tvalid, m_r.tdata, exp_r[i]);
      end
      checks++;
      if (m_f.tvalid !== 1'b1 || m_f.tdata !== exp_f[i]) begin
        fails++; $display("FAIL floor[%0d]: vld=%b dat=%h required 1 %h", i, m_f.tvalid, m_f.tdata, exp_f[i]);
      end
    end
    s_r.tvalid = 1'b0;
    step();
    checks++;
    if (m_r.tvalid !== 1'b0 || stk_r !== 1'b0) begin
      fails++; $display("FAIL round_drain: vld=%b stk=%b required 0 0", m_r.tvalid, stk_r);
    end
  endtask

  // Sends one sample to the 16-bit DUT, checks the result, lets it transfer.
  task automatic send_s(input logic [31:0] d, input logic [15:0] exp_d, input logic exp_stk,
                        input logic clr_on_xfer, input string nm);
    s_s.tdata = d; s_s.tvalid = 1'b1; m_s.tready = 1'b1;
    step();
    s_s.tvalid = 1'b0;
    checks++;
    if (m_s.tvalid !== 1'b1 || m_s.tdata !== exp_d) begin
      fails++; $display("FAIL %s_data: vld=%b dat=%h required 1 %h", nm, m_s.tvalid, m_s.tdata, exp_d);
    end
    clr_s = clr_on_xfer;
    step();
    clr_s = 1'b0;
    checks++;
    if (stk_s !== exp_stk) begin
      fails++; $display("FAIL %s_sticky: got %b required %b", nm, stk_s, exp_stk);
    end
  endtask

  task automatic clear_s();
    clr_s = 1'b1;
    step();
    clr_s = 1'b0;
    checks++;
    if (stk_s !== 1'b0) begin
      fails++; $display("FAIL sat_clr: got %b required 0", stk_s);
    end
  endtask

  task automatic test_saturation();
    send_s(32'h7FFF_FFFF, 16'h7FFF, 1'b1, 1'b0, "sat_pos");
    clear_s();
    send_s(32'h8000_0000, 16'h8000, 1'b1, 1'b0, "sat_neg");
    clear_s();
    send_s(32'h0007_FFF0, 16'h7FFF, 1'b0, 1'b0, "no_sat_max");
    send_s(32'h7FFF_FFFF, 16'h7FFF, 1'b1, 1'b1, "set_wins");
    clear_s();
  endtask

  task automatic test_backpressure();
    int idx = 0, got = 0, cyc = 0;
    logic sv, ov, srdy, mv_prev;
    logic [31:0] od;
    mv_prev = 1'b0;
    while (got < 20 && cyc < 600) begin
      s_r.tvalid = (idx < 20);
      s_r.tdata  = 32'((idx + 1) * 16);
      m_r.tready = 1'($urandom_range(0, 1));
      sv = s_r.tvalid & s_r.tready;
      ov = m_r.tvalid & m_r.tready;
      mv_prev = m_r.tvalid;
      od = m_r.tdata;
      srdy = s_r.tready;
      step();
      cyc++;
      if (sv) idx++;
      if (ov) begin
        checks++;
        if (od !== 32'(got + 1)) begin
          fails++; $display("FAIL bp_order[%0d]: got %0d required %0d", got, od, got + 1);
        end
        got++;
      end
      if (mv_prev && !ov) begin
        checks++;
        if (m_r.tvalid !== 1'b1 || m_r.tdata !== od) begin
          fails++; $display("FAIL bp_stable: vld=%b dat=%h required 1 %h", m_r.tvalid, m_r.tdata, od);
        end
      end
      if (!srdy && ov) begin
        checks++;
        if (s_r.tready !== 1'b1) begin
          fails++; $display("FAIL bp_rdy_drain: got %b required 1", s_r.tready);
        end
      end
    end
    s_r.tvalid = 1'b0;
    m_r.tready = 1'b1;
    checks++;
    if (got != 20 || idx != 20) begin
      fails++; $display("FAIL bp_count: received %0d sent %0d required 20 20", got, idx);
    end
    step();
    checks++;
    if (m_r.tvalid !== 1'b0) begin
      fails++; $display("FAIL bp_no_dup: vld=%b required 0", m_r.tvalid);
    end
  endtask

  task automatic test_round_trip();
    logic [31:0] tmp;
    logic [31:0] x;
    m_r.tready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tmp = $urandom;
      if (i == 0) tmp = 32'h0800_0000;   // most negative 28-bit value
      if (i == 1) tmp = 32'h07FF_FFFF;   // most positive 28-bit value
      x = {{4{tmp[27]}}, tmp[27:0]};
      s_r.tdata = {tmp[27:0], 4'b0000};
      s_r.tvalid = 1'b1;
      step();
      checks++;
      if (m_r.tvalid !== 1'b1 || m_r.tdata !== x) begin
        fails++; $display("FAIL round_trip[%0d]: vld=%b dat=%h required 1 %h", i, m_r.tvalid, m_r.tdata, x);
      end
    end
    s_r.tvalid = 1'b0;
    step();
  endtask

  task automatic test_reset_full();
    m_r.tready = 1'b0;
    s_r.tvalid = 1'b1; s_r.tdata = 32'd160;
    step();
    s_r.tdata = 32'd320;
    step();
    s_r.tvalid = 1'b0;
    checks++;
    if (m_r.tvalid !== 1'b1 || m_r.tdata !== 32'd10 || s_r.tready !== 1'b0) begin
      fails++; $display("FAIL full_state: vld=%b dat=%h rdy=%b required 1 0000000a 0",
                        m_r.tvalid, m_r.tdata, s_r.tready);
    end
    #2 aresetn = 1'b0;
    #1;
    checks++;
    if (m_r.tvalid !== 1'b0 || s_r.tready !== 1'b0 || m_r.tdata !== 32'h0) begin
      fails++; $display("FAIL async_reset: vld=%b rdy=%b dat=%h required 0 0 0", m_r.tvalid, s_r.tready, m_r.tdata);
    end
    step();
    aresetn = 1'b1;
    m_r.tready = 1'b1;
    #1;
    checks++;
    if (s_r.tready !== 1'b0) begin
      fails++; $display("FAIL rst_release_rdy: got %b required 0", s_r.tready);
    end
    step();
    checks++;
    if (s_r.tready !== 1'b1) begin
      fails++; $display("FAIL rst_release_edge: got %b required 1", s_r.tready);
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (m_r.tvalid !== 1'b0) begin
        fails++; $display("FAIL no_stale[%0d]: vld=%b required 0", i, m_r.tvalid);
      end
      step();
    end
  endtask

  initial begin
    test_reset();
    test_round_floor();
    test_saturation();
    test_backpressure();
    test_round_trip();
    test_reset_full();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
